// File: rtl/mic_pkg.sv
// Shared definitions for the microphone detection path: collector states,
// datapath widths and the default array geometry used by the threshold channels.
package mic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2
    } state_t;

    localparam int TIME_W     = 32;
    localparam int DROP_W     = 16;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_WINDOW = 50000;

endpackage

// File: rtl/lowest_set_index.sv
// Combinational priority encoder: index of the lowest set bit of mask, plus
// a flag telling whether any bit is set at all.
module lowest_set_index #(
    parameter int W  = 4,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  mask,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        idx = '0;
        any = |mask;
        // Walk downwards so the lowest set bit is the last one written.
        for (int i = W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/detect_collector.sv
// Collects per-channel detection times into one arrival-time frame per
// acoustic event and holds it until the CPU acknowledges it.
module detect_collector
    import mic_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int WINDOW = DEF_WINDOW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ch_valid,
    input  logic [TIME_W*NUM_CH-1:0]   ch_time,
    output logic [NUM_CH-1:0]          ch_ack,
    output logic                       frame_valid,
    output logic [NUM_CH-1:0]          frame_mask,
    output logic [TIME_W*NUM_CH-1:0]   frame_time,
    output logic [$clog2(NUM_CH)-1:0]  frame_first,
    input  logic                       frame_ack,
    output logic [DROP_W-1:0]          drop_cnt
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(WINDOW);

    state_t                 state_reg, state_next;
    logic [NUM_CH-1:0]      mask_reg, mask_next;
    logic [IDX_W-1:0]       first_reg, first_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [DROP_W-1:0]      drop_reg, drop_next;
    logic [NUM_CH-1:0]      ack_reg;
    logic [TIME_W-1:0]      time_reg [NUM_CH];

    logic [NUM_CH-1:0]      cap;
    logic                   clear_times;
    logic                   drop_inc;
    logic [IDX_W-1:0]       first_idx;
    logic                   first_any;

    lowest_set_index #(
        .W  (NUM_CH),
        .IW (IDX_W)
    ) u_first (
        .mask (ch_valid),
        .idx  (first_idx),
        .any  (first_any)
    );

    always_comb begin
        state_next  = state_reg;
        mask_next   = mask_reg;
        first_next  = first_reg;
        cnt_next    = cnt_reg;
        cap         = '0;
        clear_times = 1'b0;
        drop_inc    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (first_any) begin
                    cap        = ch_valid;
                    mask_next  = ch_valid;
                    first_next = first_idx;
                    cnt_next   = '0;
                    state_next = (&ch_valid) ? PRESENT : COLLECT;
                end
            end
            COLLECT: begin
                cnt_next  = cnt_reg + CNT_W'(1);
                cap       = ch_valid & ~mask_reg;
                drop_inc  = |(ch_valid & mask_reg);
                mask_next = mask_reg | cap;
                // cnt_reg lags the window position by one, so WINDOW-2 here
                // means this cycle is the last one of the window.
                if ((&mask_next) || (cnt_reg == CNT_W'(WINDOW - 2))) begin
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                drop_inc = |ch_valid;
                if (frame_ack) begin
                    mask_next   = '0;
                    first_next  = '0;
                    clear_times = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        drop_next = drop_reg;
        if (drop_inc && (drop_reg != {DROP_W{1'b1}})) begin
            drop_next = drop_reg + DROP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            mask_reg  <= '0;
            first_reg <= '0;
            cnt_reg   <= '0;
            drop_reg  <= '0;
            ack_reg   <= '0;
        end else begin
            state_reg <= state_next;
            mask_reg  <= mask_next;
            first_reg <= first_next;
            cnt_reg   <= cnt_next;
            drop_reg  <= drop_next;
            ack_reg   <= ch_valid;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_time
            always_ff @(posedge clk) begin
                if (rst || clear_times) begin
                    time_reg[gi] <= '0;
                end else if (cap[gi]) begin
                    time_reg[gi] <= ch_time[gi*TIME_W +: TIME_W];
                end
            end
            assign frame_time[gi*TIME_W +: TIME_W] = time_reg[gi];
        end
    endgenerate

    assign ch_ack      = ack_reg;
    assign frame_valid = (state_reg == PRESENT);
    assign frame_mask  = mask_reg;
    assign frame_first = first_reg;
    assign drop_cnt    = drop_reg;

endmodule

// File: doc/detect_collector.md
# detect_collector

Gathers per-microphone detection events from the `Threshold` channel instances and assembles them into one arrival-time frame per acoustic event for the processor. Sits between the `NUM_CH` threshold detectors and the CPU-side register interface. Opens a collection window on the first detection and closes it when every channel has reported or the window times out. Holds the frame until the CPU acknowledges it, and counts any detections it has to discard.

## Interface
Parameters:
- `NUM_CH`, 4, number of threshold channels.
- `WINDOW`, 50000, collection window length in clk cycles, counted from the first capture.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ch_valid`  in  NUM_CH  per-channel detection pulse/level from the threshold channels.
- `ch_time`  in  32*NUM_CH  per-channel `detect_time`; channel i at [32i+31:32i].
- `ch_ack`  out  NUM_CH  one-cycle acknowledge per channel event consumed (captured or dropped).
- `frame_valid`  out  1  frame available; held until `frame_ack`.
- `frame_mask`  out  NUM_CH  channels captured in the frame.
- `frame_time`  out  32*NUM_CH  captured times; uncaptured channels read 0.
- `frame_first`  out  $clog2(NUM_CH)  lowest index among channels captured in the window's first capture cycle.
- `frame_ack`  in  1  CPU consumed the frame.
- `drop_cnt`  out  16  saturating count of discarded detections.

## Operation
- States: IDLE, COLLECT, PRESENT.
- IDLE:
  - Any `ch_valid` bit high: capture `ch_time` for every high channel, set those `frame_mask` bits, set `frame_first`, clear the window counter, go to COLLECT.
  - If all NUM_CH channels are high in that same cycle, go directly to PRESENT.
- COLLECT:
  - Counter increments every cycle.
  - Each `ch_valid` bit for a channel not yet in the mask is captured.
  - `ch_valid` for an already-captured channel is acked, not captured, and increments `drop_cnt`.
  - Go to PRESENT when the mask becomes all ones or the counter reaches WINDOW-1, whichever comes first. Captures made in the closing cycle are included.
- PRESENT:
  - `frame_valid` is 1; `frame_mask`, `frame_time` and `frame_first` are stable.
  - Every `ch_valid` is acked and dropped, with `drop_cnt` incremented.
  - `frame_ack`=1: clear the mask and times, return to IDLE.
- `frame_ack` outside PRESENT is ignored.
- `frame_ack` coinciding with `ch_valid` in PRESENT: the event is dropped. The new window opens only on a detection arriving in IDLE.
- `drop_cnt` counts 1 per cycle regardless of how many channels are dropped in that cycle. It saturates at 16'hFFFF and is cleared only by `rst`.
- `ch_ack` is asserted for every channel whose `ch_valid` was high in the previous cycle. A level-held `ch_valid` is therefore consumed once per cycle it stays high; channels must deassert on ack.
- Reset mid-operation:
  - The in-progress window is discarded.
  - All outputs return to their reset values the next cycle.
  - `ch_valid` in the reset cycle is neither captured nor acked.

## Timing
- Reset values: `ch_ack`=0, `frame_valid`=0, `frame_mask`=0, `frame_time`=0, `frame_first`=0, `drop_cnt`=0, state IDLE.
- Capture latency: `ch_valid` at cycle N means the data is registered, the mask bit is visible and `ch_ack` is high at N+1.
- Frame latency:
  - `frame_valid` rises at N+1, where N is the completing capture cycle or the timeout cycle.
  - Timeout frame: the first capture is at cycle T and `frame_valid` rises at T+WINDOW.
- Release: `frame_ack` at cycle M means `frame_valid`=0 and `frame_mask`=0 at M+1. A detection at M+1 opens a new window.
- No combinational path from any input to any output.

## Structure
- Shared package `mic_pkg`:
  - State enum {IDLE, COLLECT, PRESENT}.
  - `TIME_W`=32, `DROP_W`=16.
  - Default `WINDOW` and `NUM_CH`, shared with the threshold channel configuration.
- Sub-module `lowest_set_index`: a parameterised combinational priority encoder (mask to index, plus an any-bit flag). Used for `frame_first`.
- The window counter stays inline, `$clog2(WINDOW)` bits wide.

## Test plan
- Ch0..3 `ch_valid` pulses at cycles 10, 12, 15, 20 with times 100, 102, 105, 110:
  - Frame at cycle 21: mask 4'b1111, times as given, `frame_first`=0.
  - `ch_ack` seen at 11, 13, 16, 21.
- Only ch2 (time 500) and ch3 (time 520) fire, first at cycle 5, WINDOW=50000: `frame_valid` rises at cycle 50005, mask 4'b1100, ch0/ch1 times 0, `frame_first`=2.
- Ch1 and ch3 fire in the same IDLE cycle, then ch1 fires again in COLLECT: `frame_first`=1, second ch1 event acked, `drop_cnt`=1, ch1 time unchanged.
- Three `ch_valid` events during PRESENT, one coinciding with `frame_ack`:
  - `drop_cnt`=3.
  - Back in IDLE with empty mask.
  - No window opens until the next detection.
- `rst` asserted in COLLECT with mask 4'b0011: next cycle all outputs 0 and state IDLE; a later ch0 event opens a fresh window.
- Force 70000 dropped events: `drop_cnt` saturates at 16'hFFFF.
